sram_arbiter: RTL and testbench
===============================

SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 16, SHALL set the SRAM word width.
REQ-002 Parameter ADDR_WIDTH, default 16, SHALL set the SRAM address width.
REQ-003 Parameter NUM_REQ, default 2, SHALL set the requester count; port 0 is instruction fetch and port 1 is data.
REQ-004 Parameter LOCK_TIMEOUT, default 15, SHALL set the idle cycles allowed before a lock is released.
REQ-005 clk  in  1  SHALL be the single clock; every flop SHALL switch on its rising edge.
REQ-006 rst_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-007 req_valid  in  [NUM_REQ]  SHALL indicate a request is pending, one bit per requester.
REQ-008 req_ready  out  [NUM_REQ]  SHALL indicate the request is accepted this cycle; it is one-hot or zero.
REQ-009 req_we  in  [NUM_REQ]  SHALL select the operation per requester: 1 = write, 0 = read.
REQ-010 req_lock  in  [NUM_REQ]  SHALL request that the grant be held after this transfer.
REQ-011 req_addr  in  [NUM_REQ][ADDR_WIDTH]  SHALL carry the request address.
REQ-012 req_wdata  in  [NUM_REQ][DATA_WIDTH]  SHALL carry the write data.
REQ-013 rsp_valid  out  [NUM_REQ]  SHALL be a one-hot completion strobe, one cycle after acceptance.
REQ-014 rsp_rdata  out  DATA_WIDTH  SHALL carry the shared read data, qualified by rsp_valid.
REQ-015 sram_addr  out  ADDR_WIDTH  SHALL drive the SRAM address.
REQ-016 sram_din  out  DATA_WIDTH  SHALL drive the SRAM write data.
REQ-017 sram_wr_en  out  1  SHALL drive the SRAM write enable.
REQ-018 sram_dout  in  DATA_WIDTH  SHALL return the SRAM data, combinational from sram_addr.

Function
REQ-019 At most one request SHALL be accepted per cycle, with the grant computed combinationally from req_valid, the state and the priority pointer.
REQ-020 In state ARB, the grant SHALL go to the first valid requester at or after the pointer, searching round-robin.
REQ-021 After each accepted transfer, the pointer SHALL advance to the granted index + 1, modulo NUM_REQ.
REQ-022 Any requester with req_valid held high SHALL be granted within NUM_REQ cycles while no lock is active.
REQ-023 With a grant, the SRAM outputs SHALL follow the granted port: sram_addr/sram_din = its req_addr/req_wdata, and sram_wr_en = its req_we.
REQ-024 With no grant, sram_wr_en SHALL be 0 and sram_addr/sram_din SHALL be 0.
REQ-025 On an accepted read, sram_dout SHALL be registered into rsp_rdata, and rsp_valid[granted] SHALL be 1 in the next cycle only.
REQ-026 On an accepted write, rsp_valid[granted] SHALL pulse the next cycle, and rsp_rdata SHALL hold its previous value.
REQ-027 Back-to-back accepts SHALL sustain one transfer per cycle with 1-cycle response latency.
REQ-028 A write followed by a read of the same address in the next cycle SHALL return the written data.
REQ-029 FSM state ARB: an accepted transfer with req_lock=1 SHALL move the FSM to LOCK, record the owner and clear the timeout counter.
REQ-030 In LOCK, only the owner SHALL be grantable, and other requesters' req_ready SHALL be 0.
REQ-031 In LOCK, an owner transfer with req_lock=0 SHALL return the FSM to ARB with the pointer set to owner + 1.
REQ-032 In LOCK, each cycle with owner req_valid=0 SHALL increment the timeout counter, and an owner transfer SHALL clear it.
REQ-033 When the counter reaches LOCK_TIMEOUT, the FSM SHALL force a return to ARB with the pointer set to owner + 1.
REQ-034 The timeout counter SHALL be $clog2(LOCK_TIMEOUT+1) bits wide and SHALL saturate, never wrapping.
REQ-035 The pointer SHALL wrap from NUM_REQ-1 to 0.

Reset
REQ-036 Asserting rst_n low SHALL immediately set state=ARB, pointer=0, owner=0, counter=0, rsp_valid=0 and rsp_rdata=0.
REQ-037 A reset during LOCK or with a response pending SHALL drop that response, with no rsp_valid pulse after release.
REQ-038 During reset, sram_wr_en SHALL be 0 regardless of req_valid.

Structure
REQ-039 Package sram_arb_pkg SHALL hold the arb_state_t enum (ARB, LOCK) and the default width constants.
REQ-040 Round-robin selection SHALL be the sub-module rr_arbiter (inputs: request vector and pointer; output: one-hot grant), reused by the FSM in both states.

Verification
REQ-041 Both ports valid, reading 0x0010 (mem=0xAAAA) and 0x0020 (mem=0x5555) -> grant port 0 then port 1; rsp_valid 01 then 10; rsp_rdata 0xAAAA then 0x5555.
REQ-042 Port 1 writes 0x1234 to 0x0100, then port 0 reads 0x0100 in the next cycle -> rsp_rdata=0x1234 with rsp_valid[0].
REQ-043 Port 1 locked for 3 transfers with port 0 valid throughout -> port 0 req_ready=0 for those 3 cycles, then granted on the cycle after the unlocking transfer.
REQ-044 Port 0 locks, then drops valid -> after exactly 15 idle cycles the FSM returns to ARB and port 1 is granted the next cycle.
REQ-045 rst_n asserted mid-LOCK, one cycle after an accepted read -> no rsp_valid pulse; after release, state=ARB and pointer=0.
REQ-046 Both ports continuously valid for 100 cycles -> grants alternate exactly, 50 per port, with no cycle lacking a grant.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared types and default dimensions for the two-port SRAM arbiter.
// The enum encodes whether arbitration is open or pinned to a lock owner.
package sram_arb_pkg;

   typedef enum logic {
      ARB  = 1'b0,
      LOCK = 1'b1
   } arb_state_t;

   localparam int DEF_DATA_WIDTH   = 16;
   localparam int DEF_ADDR_WIDTH   = 16;
   localparam int DEF_NUM_REQ      = 2;
   localparam int DEF_LOCK_TIMEOUT = 15;

   // A single requester still needs a 1-bit index.
   function automatic int ptr_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: one-hot grant to the first set request at or after ptr_i.
// Rotates the request vector down by the pointer, isolates the lowest set bit, then rotates back.
module rr_arbiter
   import sram_arb_pkg::*;
#(
   parameter int N  = DEF_NUM_REQ,
   parameter int PW = ptr_width(N)
) (
   input  logic [N-1:0]  req_i,
   input  logic [PW-1:0] ptr_i,
   output logic [N-1:0]  gnt_o
);

   logic [N-1:0] req_rot;
   logic [N-1:0] gnt_rot;

   always_comb begin
      req_rot = N'({req_i, req_i} >> ptr_i);
      gnt_rot = req_rot & ~(req_rot - N'(1));
      gnt_o   = N'(({gnt_rot, gnt_rot} << ptr_i) >> N);
   end

endmodule

// File: rtl/sram_arbiter.sv
// Multi-port single-SRAM arbiter with round-robin fairness, lockable grants and
// a lock idle timeout. One transfer per cycle; responses arrive one cycle after acceptance.
module sram_arbiter
   import sram_arb_pkg::*;
#(
   parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
   parameter int NUM_REQ      = DEF_NUM_REQ,
   parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic [NUM_REQ-1:0]                   req_valid,
   output logic [NUM_REQ-1:0]                   req_ready,
   input  logic [NUM_REQ-1:0]                   req_we,
   input  logic [NUM_REQ-1:0]                   req_lock,
   input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   req_addr,
   input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_wdata,
   output logic [NUM_REQ-1:0]                   rsp_valid,
   output logic [DATA_WIDTH-1:0]                rsp_rdata,
   output logic [ADDR_WIDTH-1:0]                sram_addr,
   output logic [DATA_WIDTH-1:0]                sram_din,
   output logic                                 sram_wr_en,
   input  logic [DATA_WIDTH-1:0]                sram_dout
);

   localparam int PW = ptr_width(NUM_REQ);
   localparam int CW = (LOCK_TIMEOUT > 0) ? $clog2(LOCK_TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] TIMEOUT_VAL = CW'(LOCK_TIMEOUT);
   localparam logic [PW-1:0] LAST_IDX    = PW'(NUM_REQ - 1);

   arb_state_t                  state_q;
   logic [PW-1:0]               ptr_q;
   logic [PW-1:0]               owner_q;
   logic [CW-1:0]               cnt_q;
   logic [CW-1:0]               cnt_d;
   logic [NUM_REQ-1:0]          rsp_valid_q;
   logic [DATA_WIDTH-1:0]       rsp_rdata_q;

   logic [NUM_REQ-1:0]          arb_req;
   logic [PW-1:0]               arb_ptr;
   logic [NUM_REQ-1:0]          arb_gnt;
   logic [NUM_REQ-1:0]          gnt;
   logic [PW-1:0]               gnt_idx;
   logic                        any_gnt;
   logic                        gnt_we;
   logic                        gnt_lock;
   logic                        owner_valid;

   logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] addr_sel;
   logic [NUM_REQ-1:0][DATA_WIDTH-1:0] din_sel;

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == LAST_IDX) ? '0 : p + PW'(1);
   endfunction

   // In LOCK the same picker is reused with every requester but the owner masked off.
   always_comb begin
      owner_valid = req_valid[owner_q];
      if (state_q == LOCK) begin
         arb_req = req_valid & (NUM_REQ'(1) << owner_q);
         arb_ptr = owner_q;
      end else begin
         arb_req = req_valid;
         arb_ptr = ptr_q;
      end
   end

   rr_arbiter #(
      .N  (NUM_REQ),
      .PW (PW)
   ) u_rr (
      .req_i (arb_req),
      .ptr_i (arb_ptr),
      .gnt_o (arb_gnt)
   );

   // Nothing may reach the SRAM while reset is held.
   assign gnt = rst_n ? arb_gnt : '0;

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_sel
      assign addr_sel[gi] = gnt[gi] ? req_addr[gi]  : '0;
      assign din_sel[gi]  = gnt[gi] ? req_wdata[gi] : '0;
   end

   always_comb begin
      sram_addr = '0;
      sram_din  = '0;
      gnt_idx   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         sram_addr = sram_addr | addr_sel[i];
         sram_din  = sram_din | din_sel[i];
         if (gnt[i]) begin
            gnt_idx = PW'(i);
         end
      end
   end

   assign any_gnt    = |gnt;
   assign gnt_we     = |(gnt & req_we);
   assign gnt_lock   = |(gnt & req_lock);
   assign sram_wr_en = gnt_we;
   assign req_ready  = gnt;

   assign cnt_d = (cnt_q == TIMEOUT_VAL) ? cnt_q : cnt_q + CW'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ARB;
         ptr_q       <= '0;
         owner_q     <= '0;
         cnt_q       <= '0;
         rsp_valid_q <= '0;
         rsp_rdata_q <= '0;
      end else begin
         rsp_valid_q <= gnt;
         if (any_gnt && !gnt_we) begin
            rsp_rdata_q <= sram_dout;
         end
         case (state_q)
            ARB: begin
               if (any_gnt) begin
                  ptr_q <= next_ptr(gnt_idx);
                  if (gnt_lock) begin
                     state_q <= LOCK;
                     owner_q <= gnt_idx;
                     cnt_q   <= '0;
                  end
               end
            end
            LOCK: begin
               if (any_gnt) begin
                  cnt_q <= '0;
                  if (!gnt_lock) begin
                     state_q <= ARB;
                     ptr_q   <= next_ptr(owner_q);
                  end
               end else if (!owner_valid) begin
                  // Idle owner: release once the idle count hits the limit.
                  cnt_q <= cnt_d;
                  if (cnt_d == TIMEOUT_VAL) begin
                     state_q <= ARB;
                     ptr_q   <= next_ptr(owner_q);
                  end
               end
            end
            default: state_q <= ARB;
         endcase
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: directed scenarios plus a per-cycle reference model
// (round-robin/lock rules and a shadow memory) checked on every falling edge.
module tb_sram_arbiter;

   localparam int DW = 16;
   localparam int AW = 16;
   localparam int NR = 2;
   localparam int LT = 15;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                     rst_n;
   logic [NR-1:0]            req_valid, req_ready, req_we, req_lock, rsp_valid;
   logic [NR-1:0][AW-1:0]    req_addr;
   logic [NR-1:0][DW-1:0]    req_wdata;
   logic [DW-1:0]            rsp_rdata, sram_din, sram_dout;
   logic [AW-1:0]            sram_addr;
   logic                     sram_wr_en;

   logic [DW-1:0] sram_mem [0:65535];
   logic [DW-1:0] ref_mem  [0:65535];

   int n_tests = 0;
   int n_fail  = 0;

   sram_arbiter #(
      .DATA_WIDTH   (DW),
      .ADDR_WIDTH   (AW),
      .NUM_REQ      (NR),
      .LOCK_TIMEOUT (LT)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_lock   (req_lock),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_rdata  (rsp_rdata),
      .sram_addr  (sram_addr),
      .sram_din   (sram_din),
      .sram_wr_en (sram_wr_en),
      .sram_dout  (sram_dout)
   );

   // SRAM device: synchronous write, combinational read
   always @(posedge clk) if (sram_wr_en) sram_mem[sram_addr] <= sram_din;
   assign sram_dout = sram_mem[sram_addr];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   bit             m_locked;
   int             m_owner, m_ptr, m_idle;
   logic [NR-1:0]  m_rsp_valid;
   logic [DW-1:0]  m_rdata;

   function automatic void model_reset();
      m_locked    = 0;
      m_owner     = 0;
      m_ptr       = 0;
      m_idle      = 0;
      m_rsp_valid = '0;
      m_rdata     = '0;
   endfunction

   function automatic int exp_grant();
      if (!rst_n) return -1;
      if (m_locked) return req_valid[m_owner] ? m_owner : -1;
      for (int k = 0; k < NR; k++) begin
         int idx;
         idx = (m_ptr + k) % NR;
         if (req_valid[idx]) return idx;
      end
      return -1;
   endfunction

   function automatic void model_step(input int g);
      m_rsp_valid = '0;
      if (g >= 0) begin
         m_rsp_valid[g] = 1'b1;
         if (req_we[g]) ref_mem[req_addr[g]] = req_wdata[g];
         else           m_rdata = ref_mem[req_addr[g]];
      end
      if (m_locked) begin
         if (g >= 0) begin
            m_idle = 0;
            if (!req_lock[g]) begin
               m_locked = 0;
               m_ptr    = (m_owner + 1) % NR;
            end
         end else begin
            m_idle++;
            if (m_idle >= LT) begin
               m_locked = 0;
               m_ptr    = (m_owner + 1) % NR;
            end
         end
      end else if (g >= 0) begin
         m_ptr = (g + 1) % NR;
         if (req_lock[g]) begin
            m_locked = 1;
            m_owner  = g;
            m_idle   = 0;
         end
      end
   endfunction

   initial begin
      int            g;
      logic [NR-1:0] e_ready;
      model_reset();
      forever begin
         @(negedge clk);
         if (!rst_n) model_reset();
         g       = exp_grant();
         e_ready = '0;
         if (g >= 0) e_ready[g] = 1'b1;
         check("model_req_ready", 32'(req_ready), 32'(e_ready));
         check("model_sram_wr_en", 32'(sram_wr_en), (g >= 0) ? 32'(req_we[g]) : 32'd0);
         check("model_sram_addr", 32'(sram_addr), (g >= 0) ? 32'(req_addr[g]) : 32'd0);
         check("model_sram_din", 32'(sram_din), (g >= 0) ? 32'(req_wdata[g]) : 32'd0);
         check("model_rsp_valid", 32'(rsp_valid), 32'(m_rsp_valid));
         check("model_rsp_rdata", 32'(rsp_rdata), 32'(m_rdata));
         @(posedge clk);
         if (!rst_n) model_reset();
         else        model_step(exp_grant());
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic set_in(input logic [NR-1:0] v, input logic [NR-1:0] we, input logic [NR-1:0] lk,
                         input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                         input logic [DW-1:0] d0, input logic [DW-1:0] d1);
      req_valid    = v;
      req_we       = we;
      req_lock     = lk;
      req_addr[0]  = a0;
      req_addr[1]  = a1;
      req_wdata[0] = d0;
      req_wdata[1] = d1;
   endtask

   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt0, cnt1;
      rst_n = 1'b0;
      for (int i = 0; i < 65536; i++) begin
         sram_mem[i] = '0;
         ref_mem[i]  = '0;
      end
      sram_mem[16'h0010] = 16'hAAAA;  ref_mem[16'h0010] = 16'hAAAA;
      sram_mem[16'h0020] = 16'h5555;  ref_mem[16'h0020] = 16'h5555;
      // writes requested while reset is held must not reach the SRAM
      set_in(2'b11, 2'b11, 2'b00, 16'h0030, 16'h0040, 16'h1111, 16'h2222);
      repeat (2) next_cyc();
      mid();
      check("rst_wr_en", 32'(sram_wr_en), 32'd0);
      check("rst_ready", 32'(req_ready), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);

      // two reads, both ports valid
      next_cyc();
      rst_n = 1'b1;
      set_in(2'b11, 2'b00, 2'b00, 16'h0010, 16'h0020, 16'h0, 16'h0);
      mid();
      check("rr_first_port0", 32'(req_ready), 32'h1);
      check("rr_first_addr", 32'(sram_addr), 32'h0010);
      next_cyc();
      mid();
      check("rr_second_port1", 32'(req_ready), 32'h2);
      check("rr_rsp_valid_01", 32'(rsp_valid), 32'h1);
      check("rr_rdata_aaaa", 32'(rsp_rdata), 32'hAAAA);
      next_cyc();
      set_in(2'b00, 2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0);
      mid();
      check("rr_rsp_valid_10", 32'(rsp_valid), 32'h2);
      check("rr_rdata_5555", 32'(rsp_rdata), 32'h5555);

      // write then read-after-write
      next_cyc();
      set_in(2'b10, 2'b10, 2'b00, 16'h0, 16'h0100, 16'h0, 16'h1234);
      mid();
      check("raw_wr_ready", 32'(req_ready), 32'h2);
      check("raw_wr_en", 32'(sram_wr_en), 32'h1);
      next_cyc();
      set_in(2'b01, 2'b00, 2'b00, 16'h0100, 16'h0, 16'h0, 16'h0);
      mid();
      check("raw_rd_ready", 32'(req_ready), 32'h1);
      check("raw_wr_rsp", 32'(rsp_valid), 32'h2);
      check("raw_rdata_held", 32'(rsp_rdata), 32'h5555);
      next_cyc();
      set_in(2'b00, 2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0);
      mid();
      check("raw_rsp_valid", 32'(rsp_valid), 32'h1);
      check("raw_rdata_1234", 32'(rsp_rdata), 32'h1234);

      // port 1 holds a lock for three transfers while port 0 waits
      next_cyc();
      set_in(2'b11, 2'b10, 2'b10, 16'h0010, 16'h0200, 16'h0, 16'hBEEF);
      for (int k = 0; k < 3; k++) begin
         if (k == 2) req_lock = 2'b00;
         mid();
         check("lock_p1_held", 32'(req_ready), 32'h2);
         next_cyc();
      end
      mid();
      check("lock_p0_after_unlock", 32'(req_ready), 32'h1);
      next_cyc();
      set_in(2'b00, 2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0);
      mid();

      // port 0 locks then goes idle: 15 idle cycles then release
      next_cyc();
      set_in(2'b01, 2'b00, 2'b01, 16'h0010, 16'h0, 16'h0, 16'h0);
      mid();
      check("to_lock_accept", 32'(req_ready), 32'h1);
      next_cyc();
      set_in(2'b10, 2'b00, 2'b00, 16'h0, 16'h0020, 16'h0, 16'h0);
      for (int i = 0; i < LT; i++) begin
         mid();
         check("to_idle_blocked", 32'(req_ready), 32'h0);
         next_cyc();
      end
      mid();
      check("to_p1_after_timeout", 32'(req_ready), 32'h2);
      next_cyc();
      set_in(2'b00, 2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0);
      mid();

      // reset while locked with a read response pending
      next_cyc();
      set_in(2'b01, 2'b00, 2'b01, 16'h0020, 16'h0, 16'h0, 16'h0);
      mid();
      check("rstlock_accept", 32'(req_ready), 32'h1);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      set_in(2'b00, 2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0);
      mid();
      check("rstlock_no_rsp", 32'(rsp_valid), 32'h0);
      check("rstlock_rdata_clr", 32'(rsp_rdata), 32'h0);
      next_cyc();
      mid();
      check("rstlock_no_rsp2", 32'(rsp_valid), 32'h0);
      next_cyc();
      rst_n = 1'b1;
      set_in(2'b11, 2'b00, 2'b00, 16'h0010, 16'h0020, 16'h0, 16'h0);
      mid();
      check("rstlock_ptr0", 32'(req_ready), 32'h1);
      check("rstlock_rsp_quiet", 32'(rsp_valid), 32'h0);
      next_cyc();
      mid();
      check("rstlock_arb_p1", 32'(req_ready), 32'h2);
      next_cyc();

      // sustained contention: exact alternation
      cnt0 = 0;
      cnt1 = 0;
      for (int c = 0; c < 100; c++) begin
         mid();
         if (req_ready == 2'b01) cnt0++;
         else if (req_ready == 2'b10) cnt1++;
         check("fair_alternate", 32'(req_ready), (c % 2 == 0) ? 32'h1 : 32'h2);
         next_cyc();
      end
      check("fair_port0_count", 32'(cnt0), 32'd50);
      check("fair_port1_count", 32'(cnt1), 32'd50);

      set_in(2'b00, 2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0);
      repeat (3) next_cyc();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
